// File: rtl/grid_write_arbiter_if.sv
// Write-port bundle between the game-logic requesters and the grid_register arbiter.
// The master side drives requests and words; the slave side is the arbiter itself.
interface grid_write_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int WORD_W = 36
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*WORD_W-1:0] word_in;
   logic                    vblnk_in;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic [WORD_W-1:0]       wr_word;
   logic                    wr_valid;
   logic                    busy;

   modport master (
      output req, word_in, vblnk_in,
      input  gnt, ack, wr_word, wr_valid, busy
   );

   modport slave (
      input  req, word_in, vblnk_in,
      output gnt, ack, wr_word, wr_valid, busy
   );
endinterface

// File: rtl/grid_write_arbiter.sv
// Round-robin owner of the single grid_register write port.
// Define VBLANK_GATE_EN to start writes only while vblnk_in is high.
//
// state     | meaning
// S_IDLE    | no owner; pick next requester round-robin when gate is open
// S_HOLD    | word latched, wr_valid high for HOLD_CYCLES cycles
// S_RELEASE | wr_valid low, ack pulse to the granted requester
module grid_write_arbiter #(
   parameter int N_REQ       = 3,
   parameter int WORD_W      = 36,
   parameter int HOLD_CYCLES = 2
) (
   input logic                clk,
   input logic                rst,
   grid_write_arbiter_if.slave bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HOLD    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [N_REQ-1:0]   gnt_q;
   logic [WORD_W-1:0]  wr_word_q;
   logic [PTR_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   hold_cnt;

   logic               gate_open;
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [WORD_W-1:0]  win_word;
   logic               start;
   logic               hold_done;

`ifdef VBLANK_GATE_EN
   assign gate_open = bus.vblnk_in;
`else
   logic unused_vblnk;
   assign unused_vblnk = bus.vblnk_in;
   assign gate_open    = 1'b1;
`endif

   // Scan from the largest offset down so the requester closest after rr_ptr wins.
   always_comb begin
      int cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int off = N_REQ; off >= 1; off--) begin
         cand = (int'(rr_ptr) + off) % N_REQ;
         if (bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   assign win_word  = bus.word_in[int'(win_idx)*WORD_W +: WORD_W];
   assign start     = gate_open & win_found;
   assign hold_done = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_HOLD;
         S_HOLD:    if (hold_done) state_nxt = S_RELEASE;
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q     <= '0;
         wr_word_q <= '0;
         rr_ptr    <= PTR_W'(N_REQ - 1);
         hold_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               hold_cnt <= '0;
               if (start) begin
                  gnt_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                  wr_word_q <= win_word;
                  rr_ptr    <= win_idx;
               end
            end
            S_HOLD: begin
               hold_cnt <= hold_done ? '0 : hold_cnt + CNT_W'(1);
            end
            S_RELEASE: begin
               gnt_q    <= '0;
               hold_cnt <= '0;
            end
            default: begin
               gnt_q    <= '0;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.busy     = (state != S_IDLE);
      bus.wr_valid = (state == S_HOLD);
      bus.ack      = (state == S_RELEASE) ? gnt_q : '0;
   end

   assign bus.gnt     = gnt_q;
   assign bus.wr_word = wr_word_q;

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Directed bench for grid_write_arbiter with an ack-driven scoreboard.
module tb_grid_write_arbiter;
   localparam int N = 3;
   localparam int W = 36;
   localparam int H = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   grid_write_arbiter_if #(.N_REQ(N), .WORD_W(W)) bus ();

   grid_write_arbiter #(.N_REQ(N), .WORD_W(W), .HOLD_CYCLES(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int           idx;
      logic [W-1:0] word;
   } exp_t;

   exp_t         exp_q[$];
   int           tests_run    = 0;
   int           tests_failed = 0;
   int           vcnt         = 0;
   logic [W-1:0] cap_word     = '0;
   logic [127:0] rnd;
   int           cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_word(input int i, input logic [W-1:0] w);
      bus.word_in[i*W +: W] = w;
   endtask

   task automatic push(input int i, input logic [W-1:0] w);
      exp_t e;
      set_word(i, w);
      e.idx  = i;
      e.word = w;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Monitor: tracks each wr_valid burst and retires one expected write per ack pulse.
   always @(negedge clk) begin
      if (!rst) begin
         vcnt = 0;
      end else begin
         check("gnt_onehot", 64'($onehot0(bus.gnt)), 64'd1);
         check("ack_onehot", 64'($onehot0(bus.ack)), 64'd1);
         if (bus.wr_valid) begin
            if (vcnt == 0) cap_word = bus.wr_word;
            else check("word_stable", bus.wr_word, cap_word);
            vcnt++;
         end
         if (bus.ack != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", bus.ack, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ack_idx", bus.ack, 64'd1 << e.idx);
               check("ack_gnt", bus.gnt, 64'd1 << e.idx);
               check("wr_word", cap_word, e.word);
               check("valid_len", vcnt, H);
            end
            vcnt = 0;
         end
      end
   end

   initial begin
      bus.req      = '0;
      bus.word_in  = '0;
      bus.vblnk_in = 1'b0;

      // 1: held in reset with random inputs
      for (int i = 0; i < 4; i++) begin
         rnd          = {$urandom, $urandom, $urandom, $urandom};
         bus.req      = N'($urandom);
         bus.word_in  = rnd[N*W-1:0];
         bus.vblnk_in = 1'($urandom);
         @(negedge clk);
         check("rst_gnt", bus.gnt, 0);
         check("rst_ack", bus.ack, 0);
         check("rst_valid", bus.wr_valid, 0);
         check("rst_word", bus.wr_word, 0);
         check("rst_busy", bus.busy, 0);
      end
      bus.req      = '0;
      bus.vblnk_in = 1'b1;
      rst          = 1'b1;

      // 2: single request latency
      @(negedge clk);
      push(1, 36'h1_0000_0042);
      bus.req = 3'b010;
      @(negedge clk);
      check("t2_valid_c1", bus.wr_valid, 1);
      check("t2_word_c1", bus.wr_word, 36'h1_0000_0042);
      check("t2_gnt_c1", bus.gnt, 3'b010);
      check("t2_busy_c1", bus.busy, 1);
      bus.req = '0;
      @(negedge clk);
      check("t2_valid_c2", bus.wr_valid, 1);
      check("t2_word_c2", bus.wr_word, 36'h1_0000_0042);
      @(negedge clk);
      check("t2_ack_c3", bus.ack, 3'b010);
      check("t2_valid_c3", bus.wr_valid, 0);
      check("t2_gnt_c3", bus.gnt, 3'b010);
      @(negedge clk);
      check("t2_busy_c4", bus.busy, 0);
      check("t2_gnt_c4", bus.gnt, 0);
      check("t2_ack_c4", bus.ack, 0);

      // 3: all three held high -> 0,1,2,0 every 4 cycles
      do_reset();
      push(0, 36'hA_0000_00A0);
      push(1, 36'hB_0000_00B1);
      push(2, 36'hC_0000_00C2);
      push(0, 36'hA_0000_00A0);
      bus.req = 3'b111;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c % 4 == 1) check("t3_gnt_order", bus.gnt, 64'd1 << ((c / 4) % 3));
      end
      bus.req = '0;
      repeat (2) @(negedge clk);

      // 4: request dropped during HOLD
      do_reset();
      push(2, 36'hF_DEAD_BEEF);
      bus.req = 3'b100;
      @(negedge clk);
      check("t4_valid_c1", bus.wr_valid, 1);
      bus.req = '0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.ack[2]) cnt++;
      end
      check("t4_ack_count", cnt, 1);

      // 5: reset during HOLD aborts the write
      do_reset();
      set_word(1, 36'h5_5555_5555);
      bus.req = 3'b010;
      @(negedge clk);
      check("t5_busy_hold", bus.busy, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_abort_gnt", bus.gnt, 0);
      check("t5_abort_valid", bus.wr_valid, 0);
      check("t5_abort_busy", bus.busy, 0);
      check("t5_abort_word", bus.wr_word, 0);
      check("t5_abort_ack", bus.ack, 0);
      bus.req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      push(0, 36'h0_1234_5670);
      push(2, 36'h2_89AB_CDE2);
      bus.req = 3'b101;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) check("t5_first_gnt", bus.gnt, 3'b001);
         if (c == 5) check("t5_second_gnt", bus.gnt, 3'b100);
      end
      bus.req = '0;
      repeat (2) @(negedge clk);

      // 6: vertical blanking gate
      do_reset();
      bus.vblnk_in = 1'b0;
`ifdef VBLANK_GATE_EN
      set_word(0, 36'h6_0000_0006);
      bus.req = 3'b001;
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.gnt != '0) cnt++;
      end
      check("t6_gated_gnt", cnt, 0);
      push(0, 36'h6_0000_0006);
      bus.vblnk_in = 1'b1;
      @(negedge clk);
      check("t6_open_gnt", bus.gnt, 3'b001);
      bus.req      = '0;
      bus.vblnk_in = 1'b0;
`else
      push(0, 36'h6_0000_0006);
      bus.req = 3'b001;
      @(negedge clk);
      check("t6_ungated_gnt", bus.gnt, 3'b001);
      bus.req = '0;
`endif
      repeat (5) @(negedge clk);

      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
